nonce_dispatcher: RTL and testbench

- Sits between uart_comm and NUM_CORES hashing cores, all in the hash_clk domain.
- Takes a job (midstate, work_data, nonce_min/nonce_max) on the new_work pulse and splits the nonce range into equal contiguous slices.
- Loads the slices into the cores one per cycle and tracks core completion.
- Arbitrates golden nonces from the cores round-robin into a single valid/ready stream toward uart_comm; raises need_work when every active core is done.

---
 rtl/nonce_dispatcher_pkg.sv | 15 +
 rtl/nonce_dispatcher_arbiter.sv | 112 +++++++++++
 rtl/nonce_dispatcher.sv | 211 +++++++++++++++++++++
 tb/tb_nonce_dispatcher.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_dispatcher_pkg.sv
// Shared types and widths for the nonce dispatcher and its golden-nonce arbiter.
package nonce_dispatcher_pkg;
  localparam int NONCE_W    = 32;
  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;
  localparam int OVF_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ABORT = 3'd4
  } state_e;
endpackage

// File: rtl/nonce_dispatcher_arbiter.sv
// Per-core golden-nonce slots, round-robin pick into a single held output
// register, and a saturating count of nonces dropped on a full slot.
module rr_nonce_arbiter
  import nonce_dispatcher_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int CORE_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_CORES-1:0]         found,
  input  logic [NONCE_W*NUM_CORES-1:0] nonce_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [NONCE_W-1:0]           out_nonce,
  output logic [OVF_W-1:0]             overflow_cnt
);

  logic [NUM_CORES-1:0]  slot_vld_q, slot_vld_d;
  logic [NONCE_W-1:0]    slot_nonce_q [NUM_CORES];
  logic [NONCE_W-1:0]    slot_nonce_d [NUM_CORES];
  logic                  out_vld_q, out_vld_d;
  logic [NONCE_W-1:0]    out_nonce_q, out_nonce_d;
  logic [CORE_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OVF_W-1:0]      ovf_q, ovf_d;
  logic                  cand_hit;
  logic                  take;
  logic [CORE_IDX_W-1:0] cand_idx;
  logic [CORE_IDX_W-1:0] pick_idx;
  logic [OVF_W:0]        drop_cnt;

  function automatic logic [OVF_W-1:0] sat_add(input logic [OVF_W-1:0] base,
                                               input logic [OVF_W:0]   inc);
    logic [OVF_W:0] sum;
    sum = {1'b0, base} + inc;
    return sum[OVF_W] ? {OVF_W{1'b1}} : sum[OVF_W-1:0];
  endfunction

  // First occupied slot at or after the round-robin pointer, wrapping.
  always_comb begin
    cand_hit = 1'b0;
    cand_idx = '0;
    pick_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_idx = CORE_IDX_W'((int'(rr_ptr_q) + k) % NUM_CORES);
      if (!cand_hit && slot_vld_q[cand_idx]) begin
        cand_hit = 1'b1;
        pick_idx = cand_idx;
      end
    end
    take = cand_hit && !out_vld_q;
  end

  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_nonce_d = slot_nonce_q;
    out_vld_d    = out_vld_q;
    out_nonce_d  = out_nonce_q;
    rr_ptr_d     = rr_ptr_q;
    drop_cnt     = '0;
    if (out_vld_q && out_ready) out_vld_d = 1'b0;
    if (take) begin
      out_vld_d           = 1'b1;
      out_nonce_d         = slot_nonce_q[pick_idx];
      slot_vld_d[pick_idx] = 1'b0;
      rr_ptr_d            = CORE_IDX_W'((int'(pick_idx) + 1) % NUM_CORES);
    end
    // A slot emptied by this cycle's pick can take a new nonce immediately.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (found[i]) begin
        if (slot_vld_d[i]) begin
          drop_cnt = drop_cnt + (OVF_W+1)'(1);
        end else begin
          slot_vld_d[i]   = 1'b1;
          slot_nonce_d[i] = nonce_in[NONCE_W*i +: NONCE_W];
        end
      end
    end
    if (flush) begin
      slot_vld_d = '0;
      out_vld_d  = 1'b0;
      drop_cnt   = '0;
    end
    ovf_d = sat_add(ovf_q, drop_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q  <= '0;
      out_vld_q   <= 1'b0;
      out_nonce_q <= '0;
      rr_ptr_q    <= '0;
      ovf_q       <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      out_vld_q   <= out_vld_d;
      out_nonce_q <= out_nonce_d;
      rr_ptr_q    <= rr_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_nonce_q <= slot_nonce_d;
  end

  assign out_valid    = out_vld_q;
  assign out_nonce    = out_nonce_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: rtl/nonce_dispatcher.sv
// Splits a nonce range into equal slices, loads them into the hashing cores,
// tracks completion and forwards golden nonces through a round-robin arbiter.
module nonce_dispatcher
  import nonce_dispatcher_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int CORE_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                         hash_clk,
  input  logic                         rst_n,
  input  logic                         new_work,
  input  logic [MIDSTATE_W-1:0]        midstate,
  input  logic [DATA_W-1:0]            work_data,
  input  logic [NONCE_W-1:0]           nonce_min,
  input  logic [NONCE_W-1:0]           nonce_max,
  output logic                         job_error,
  output logic                         need_work,
  output logic [MIDSTATE_W-1:0]        core_midstate,
  output logic [DATA_W-1:0]            core_data,
  output logic [NUM_CORES-1:0]         core_load,
  output logic [NONCE_W-1:0]           core_nonce_start,
  output logic [NONCE_W-1:0]           core_nonce_end,
  output logic                         core_abort,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NONCE_W*NUM_CORES-1:0] core_nonce,
  output logic                         golden_valid,
  input  logic                         golden_ready,
  output logic [NONCE_W-1:0]           golden_nonce,
  output logic [OVF_W-1:0]             overflow_cnt
);

  state_e                state_q, state_d;
  logic [MIDSTATE_W-1:0] midstate_q, midstate_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NONCE_W-1:0]    min_q, min_d, max_q, max_d;
  logic [NONCE_W-1:0]    chunk_q, chunk_d;
  logic [CORE_IDX_W-1:0] last_idx_q, last_idx_d;
  logic [CORE_IDX_W-1:0] load_idx_q, load_idx_d;
  logic [NUM_CORES-1:0]  core_load_q, core_load_d;
  logic [NONCE_W-1:0]    start_q, start_d, end_q, end_d;
  logic [NUM_CORES-1:0]  active_q, active_d;
  logic                  need_work_q, need_work_d;
  logic                  job_error_q, job_error_d;
  logic                  core_abort_q, core_abort_d;
  logic                  flush;
  logic [NONCE_W:0]      range33;
  logic [NONCE_W-1:0]    calc_chunk;
  logic [CORE_IDX_W-1:0] calc_last;
  logic [CORE_IDX_W-1:0] next_idx;
  logic [NONCE_W-1:0]    next_start;

  function automatic logic [NONCE_W:0] job_range(input logic [NONCE_W-1:0] lo,
                                                 input logic [NONCE_W-1:0] hi);
    return {1'b0, hi} - {1'b0, lo} + (NONCE_W+1)'(1);
  endfunction

  always_comb begin
    range33    = job_range(min_q, max_q);
    calc_chunk = NONCE_W'(range33 >> CORE_IDX_W);
    calc_last  = (range33 < (NONCE_W+1)'(NUM_CORES)) ? '0 : CORE_IDX_W'(NUM_CORES - 1);
    next_idx   = load_idx_q + CORE_IDX_W'(1);
    next_start = start_q + chunk_q;

    state_d      = state_q;
    midstate_d   = midstate_q;
    data_d       = data_q;
    min_d        = min_q;
    max_d        = max_q;
    chunk_d      = chunk_q;
    last_idx_d   = last_idx_q;
    load_idx_d   = load_idx_q;
    core_load_d  = '0;
    start_d      = start_q;
    end_d        = end_q;
    need_work_d  = need_work_q;
    job_error_d  = 1'b0;
    core_abort_d = 1'b0;
    flush        = 1'b0;
    active_d     = (active_q | core_load_q) & ~core_done;

    if (new_work && state_q != ST_ABORT) begin
      midstate_d = midstate;
      data_d     = work_data;
      min_d      = nonce_min;
      max_d      = nonce_max;
    end

    if (new_work && (state_q inside {ST_CALC, ST_LOAD, ST_RUN})) begin
      state_d      = ST_ABORT;
      core_abort_d = 1'b1;
      active_d     = '0;
      flush        = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (new_work) begin
            if (nonce_max < nonce_min) begin
              job_error_d = 1'b1;
            end else begin
              state_d     = ST_CALC;
              need_work_d = 1'b0;
            end
          end
        end
        // Slice geometry is fixed here and core 0 is issued on the same edge.
        ST_CALC: begin
          chunk_d        = calc_chunk;
          last_idx_d     = calc_last;
          load_idx_d     = '0;
          core_load_d[0] = 1'b1;
          start_d        = min_q;
          end_d          = (calc_last == '0) ? max_q : min_q + calc_chunk - NONCE_W'(1);
          state_d        = ST_LOAD;
        end
        ST_LOAD: begin
          if (load_idx_q == last_idx_q) begin
            state_d = ST_RUN;
          end else begin
            load_idx_d            = next_idx;
            core_load_d[next_idx] = 1'b1;
            start_d               = next_start;
            end_d                 = (next_idx == last_idx_q) ? max_q
                                                             : next_start + chunk_q - NONCE_W'(1);
          end
        end
        ST_RUN: begin
          if (active_d == '0) begin
            state_d     = ST_IDLE;
            need_work_d = 1'b1;
          end
        end
        ST_ABORT: begin
          if (max_q < min_q) begin
            state_d     = ST_IDLE;
            job_error_d = 1'b1;
            need_work_d = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          need_work_d = 1'b1;
          active_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      midstate_q   <= '0;
      data_q       <= '0;
      min_q        <= '0;
      max_q        <= '0;
      chunk_q      <= '0;
      last_idx_q   <= '0;
      load_idx_q   <= '0;
      core_load_q  <= '0;
      start_q      <= '0;
      end_q        <= '0;
      active_q     <= '0;
      need_work_q  <= 1'b1;
      job_error_q  <= 1'b0;
      core_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      midstate_q   <= midstate_d;
      data_q       <= data_d;
      min_q        <= min_d;
      max_q        <= max_d;
      chunk_q      <= chunk_d;
      last_idx_q   <= last_idx_d;
      load_idx_q   <= load_idx_d;
      core_load_q  <= core_load_d;
      start_q      <= start_d;
      end_q        <= end_d;
      active_q     <= active_d;
      need_work_q  <= need_work_d;
      job_error_q  <= job_error_d;
      core_abort_q <= core_abort_d;
    end
  end

  rr_nonce_arbiter #(
    .NUM_CORES  (NUM_CORES),
    .CORE_IDX_W (CORE_IDX_W)
  ) u_arb (
    .clk          (hash_clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .found        (core_found & (active_q | core_load_q)),
    .nonce_in     (core_nonce),
    .out_ready    (golden_ready),
    .out_valid    (golden_valid),
    .out_nonce    (golden_nonce),
    .overflow_cnt (overflow_cnt)
  );

  assign job_error        = job_error_q;
  assign need_work        = need_work_q;
  assign core_midstate    = midstate_q;
  assign core_data        = data_q;
  assign core_load        = core_load_q;
  assign core_nonce_start = start_q;
  assign core_nonce_end   = end_q;
  assign core_abort       = core_abort_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Self-checking bench for nonce_dispatcher with a behavioural slice and arbiter model.
module tb_nonce_dispatcher;
  localparam int N = 4;

  logic           hash_clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           new_work = 1'b0;
  logic [255:0]   midstate = '0;
  logic [95:0]    work_data = '0;
  logic [31:0]    nonce_min = '0, nonce_max = '0;
  logic           job_error, need_work;
  logic [255:0]   core_midstate;
  logic [95:0]    core_data;
  logic [N-1:0]   core_load;
  logic [31:0]    core_nonce_start, core_nonce_end;
  logic           core_abort;
  logic [N-1:0]   core_done = '0, core_found = '0;
  logic [32*N-1:0] core_nonce = '0;
  logic           golden_valid;
  logic           golden_ready = 1'b0;
  logic [31:0]    golden_nonce;
  logic [15:0]    overflow_cnt;
  int n_checks = 0, n_fail = 0;

  always #5 hash_clk = ~hash_clk;

  nonce_dispatcher #(.NUM_CORES(N)) dut (
    .hash_clk(hash_clk), .rst_n(rst_n), .new_work(new_work), .midstate(midstate),
    .work_data(work_data), .nonce_min(nonce_min), .nonce_max(nonce_max),
    .job_error(job_error), .need_work(need_work), .core_midstate(core_midstate),
    .core_data(core_data), .core_load(core_load), .core_nonce_start(core_nonce_start),
    .core_nonce_end(core_nonce_end), .core_abort(core_abort), .core_done(core_done),
    .core_found(core_found), .core_nonce(core_nonce), .golden_valid(golden_valid),
    .golden_ready(golden_ready), .golden_nonce(golden_nonce), .overflow_cnt(overflow_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  // Reference slicing: equal division of the inclusive range, last core takes the tail.
  function automatic void slice(input logic [31:0] mn, input logic [31:0] mx, input int i,
                                output logic [31:0] s, output logic [31:0] e, output int used);
    longint unsigned rng, chunk;
    rng   = 64'(mx) - 64'(mn) + 64'd1;
    used  = (rng < 64'(N)) ? 1 : N;
    chunk = rng / 64'(N);
    if (used == 1) begin
      s = mn;
      e = mx;
    end else begin
      s = 32'(64'(mn) + 64'(i) * chunk);
      e = (i == N - 1) ? mx : 32'(64'(s) + chunk - 64'd1);
    end
  endfunction

  task automatic do_reset();
    new_work = 1'b0; core_found = '0; core_done = '0; golden_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_job(input logic [31:0] mn, input logic [31:0] mx, input string tag,
                         output int used);
    logic [255:0] ms;
    logic [95:0]  wd;
    logic [31:0]  s, e;
    ms = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    wd = {$urandom, $urandom, $urandom};
    midstate = ms; work_data = wd; nonce_min = mn; nonce_max = mx; new_work = 1'b1;
    tick();
    new_work = 1'b0;
    used = 0;
    if (mx < mn) begin
      n_checks++;
      if (job_error !== 1'b1 || need_work !== 1'b1 || core_load !== '0) begin
        n_fail++;
        $display("FAIL %s_reject: job_error=%b need_work=%b core_load=%b, want 1 1 0000",
                 tag, job_error, need_work, core_load);
      end
      for (int c = 0; c < 4; c++) begin
        tick();
        n_checks++;
        if (job_error !== 1'b0 || need_work !== 1'b1 || core_load !== '0) begin
          n_fail++;
          $display("FAIL %s_idle_after_reject: job_error=%b need_work=%b core_load=%b, want 0 1 0000",
                   tag, job_error, need_work, core_load);
        end
      end
      return;
    end
    n_checks++;
    if (need_work !== 1'b0 || core_load !== '0) begin
      n_fail++;
      $display("FAIL %s_calc: need_work=%b core_load=%b, want 0 0000", tag, need_work, core_load);
    end
    slice(mn, mx, 0, s, e, used);
    for (int i = 0; i < used; i++) begin
      slice(mn, mx, i, s, e, used);
      tick();
      n_checks++;
      if (core_load !== 4'(1 << i) || core_nonce_start !== s || core_nonce_end !== e ||
          core_midstate !== ms || core_data !== wd) begin
        n_fail++;
        $display("FAIL %s_load%0d: load=%b start=%h end=%h, want load=%b start=%h end=%h (job copy ok=%b)",
                 tag, i, core_load, core_nonce_start, core_nonce_end, 4'(1 << i), s, e,
                 (core_midstate === ms) && (core_data === wd));
      end
    end
    tick();
    n_checks++;
    if (core_load !== '0) begin
      n_fail++;
      $display("FAIL %s_load_end: core_load=%b, want 0000", tag, core_load);
    end
  endtask

  task automatic finish_job(input int used, input string tag);
    for (int i = 0; i < used; i++) begin
      core_done = 4'(1 << i);
      tick();
      core_done = '0;
      if (i < used - 1) begin
        tick();
        n_checks++;
        if (need_work !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_busy_after_done%0d: need_work=%b, want 0", tag, i, need_work);
        end
      end
    end
    n_checks++;
    if (need_work !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_need_work: need_work=%b, want 1", tag, need_work);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if (need_work !== 1'b1 || job_error !== 1'b0 || core_load !== '0 || core_abort !== 1'b0 ||
        golden_valid !== 1'b0 || golden_nonce !== '0 || overflow_cnt !== '0 ||
        core_midstate !== '0 || core_data !== '0 || core_nonce_start !== '0 || core_nonce_end !== '0) begin
      n_fail++;
      $display("FAIL reset_values: need_work=%b job_error=%b load=%b abort=%b gv=%b ovf=%h, want 1 0 0 0 0 0",
               need_work, job_error, core_load, core_abort, golden_valid, overflow_cnt);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (need_work !== 1'b1 || core_load !== '0) begin
      n_fail++;
      $display("FAIL reset_release: need_work=%b load=%b, want 1 0000", need_work, core_load);
    end
  endtask

  task automatic test_full_range();
    int used;
    run_job(32'h0000_0000, 32'hFFFF_FFFF, "full", used);
    finish_job(used, "full");
  endtask

  task automatic test_small_invalid();
    int used;
    run_job(32'd5, 32'd6, "small", used);
    finish_job(used, "small");
    run_job(32'h1F, 32'h10, "invalid", used);
  endtask

  task automatic test_random_slices();
    logic [31:0] mn, mx;
    int used;
    for (int j = 0; j < 8; j++) begin
      case (j % 4)
        0: begin mn = $urandom; mx = $urandom; end
        1: begin mn = $urandom & 32'hFFFF_FFF0; mx = mn + 32'($urandom_range(0, 6)); end
        2: begin mn = $urandom & 32'hFFFF_FFF0; mx = mn + 32'(2 + (j / 4)); end
        default: begin mn = '0; mx = $urandom; end
      endcase
      run_job(mn, mx, "rand_slice", used);
      finish_job(used, "rand_slice");
    end
  endtask

  task automatic test_round_robin();
    int used;
    do_reset();
    run_job(32'h0, 32'hFFFF_FFFF, "rr_job", used);
    golden_ready = 1'b0;
    core_nonce = {32'hBBBB_0003, 32'h0, 32'hAAAA_0001, 32'h0};
    core_found = 4'b1010;
    tick();
    core_found = '0;
    n_checks++;
    if (golden_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_latency: golden_valid=%b one cycle after find, want 0", golden_valid);
    end
    for (int c = 0; c < 9; c++) begin
      tick();
      n_checks++;
      if (golden_valid !== 1'b1 || golden_nonce !== 32'hAAAA_0001) begin
        n_fail++;
        $display("FAIL rr_first_hold%0d: valid=%b nonce=%h, want 1 aaaa0001", c, golden_valid, golden_nonce);
      end
    end
    golden_ready = 1'b1;
    tick();
    n_checks++;
    if (golden_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_after_accept: valid=%b, want 0", golden_valid);
    end
    tick();
    n_checks++;
    if (golden_valid !== 1'b1 || golden_nonce !== 32'hBBBB_0003) begin
      n_fail++;
      $display("FAIL rr_second: valid=%b nonce=%h, want 1 bbbb0003", golden_valid, golden_nonce);
    end
    tick();
    golden_ready = 1'b0;
    n_checks++;
    if (golden_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drained: valid=%b, want 0", golden_valid);
    end
    finish_job(used, "rr_job");
  endtask

  task automatic test_overflow();
    int used;
    do_reset();
    run_job(32'h0, 32'hFFFF_FFFF, "ovf_job", used);
    golden_ready = 1'b0;
    core_found = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      core_nonce = {32'h0, 32'h2222_0000 + 32'(k), 64'h0};
      tick();
    end
    core_found = '0;
    tick();
    n_checks++;
    if (overflow_cnt !== 16'd1 || golden_valid !== 1'b1 || golden_nonce !== 32'h2222_0000) begin
      n_fail++;
      $display("FAIL ovf_count: ovf=%0d valid=%b nonce=%h, want 1 1 22220000",
               overflow_cnt, golden_valid, golden_nonce);
    end
    golden_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (golden_valid !== 1'b1 || golden_nonce !== 32'h2222_0001) begin
      n_fail++;
      $display("FAIL ovf_second: valid=%b nonce=%h, want 1 22220001", golden_valid, golden_nonce);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (golden_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_dropped_absent%0d: valid=%b nonce=%h, want 0", c, golden_valid, golden_nonce);
      end
    end
    golden_ready = 1'b0;
    finish_job(used, "ovf_job");
  endtask

  task automatic test_random_arbiter();
    logic        mv [N];
    logic [31:0] mval [N];
    logic        ov, nov;
    logic [31:0] on, non;
    logic [N-1:0] f;
    int ptr, pick, ovf, used;
    do_reset();
    run_job(32'h0, 32'hFFFF_FFFF, "arb_job", used);
    for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mval[i] = '0; end
    ov = 1'b0; on = '0; ptr = 0; ovf = 0;
    for (int cyc = 0; cyc < 260; cyc++) begin
      n_checks++;
      if (golden_valid !== ov || (ov && golden_nonce !== on)) begin
        n_fail++;
        $display("FAIL arb_cycle%0d: valid=%b nonce=%h, want valid=%b nonce=%h",
                 cyc, golden_valid, golden_nonce, ov, on);
      end
      for (int i = 0; i < N; i++) f[i] = (cyc < 220) && ($urandom_range(0, 3) == 0);
      core_found   = f;
      core_nonce   = {$urandom, $urandom, $urandom, $urandom};
      golden_ready = (cyc >= 220) || ($urandom_range(0, 2) == 0);
      pick = -1;
      if (!ov)
        for (int k = 0; k < N; k++)
          if (pick < 0 && mv[(ptr + k) % N]) pick = (ptr + k) % N;
      nov = ov; non = on;
      if (ov && golden_ready) nov = 1'b0;
      if (pick >= 0) begin
        nov = 1'b1; non = mval[pick]; mv[pick] = 1'b0; ptr = (pick + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (f[i]) begin
          if (mv[i]) ovf = (ovf < 16'hFFFF) ? ovf + 1 : ovf;
          else begin mv[i] = 1'b1; mval[i] = core_nonce[32*i +: 32]; end
        end
      end
      ov = nov; on = non;
      tick();
    end
    core_found = '0; golden_ready = 1'b0;
    n_checks++;
    if (overflow_cnt !== 16'(ovf) || golden_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_final: ovf=%0d valid=%b, want ovf=%0d valid=0", overflow_cnt, golden_valid, ovf);
    end
    finish_job(used, "arb_job");
  endtask

  task automatic test_abort();
    logic [31:0] s, e;
    int used, u2;
    do_reset();
    run_job(32'h0, 32'hFFFF_FFFF, "abort_job", used);
    golden_ready = 1'b0;
    core_found = 4'b0001;
    core_nonce = {96'h0, 32'h0A0A_0001};
    tick();
    core_nonce = {96'h0, 32'h0A0A_0002};
    tick();
    core_found = '0;
    tick();
    n_checks++;
    if (golden_valid !== 1'b1 || golden_nonce !== 32'h0A0A_0001) begin
      n_fail++;
      $display("FAIL abort_pre: valid=%b nonce=%h, want 1 0a0a0001", golden_valid, golden_nonce);
    end
    nonce_min = 32'h100; nonce_max = 32'h1FF; new_work = 1'b1;
    core_found = 4'b0010;
    core_nonce = {64'h0, 32'h0B0B_0001, 32'h0};
    tick();
    new_work = 1'b0;
    core_found = 4'b0100;
    core_nonce = {32'h0, 32'h0C0C_0001, 64'h0};
    golden_ready = 1'b1;
    n_checks++;
    if (core_abort !== 1'b1 || core_load !== '0 || golden_valid !== 1'b0 || need_work !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_cycle: abort=%b load=%b valid=%b need_work=%b, want 1 0000 0 0",
               core_abort, core_load, golden_valid, need_work);
    end
    tick();
    core_found = '0;
    n_checks++;
    if (core_abort !== 1'b0 || core_load !== '0 || golden_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_calc: abort=%b load=%b valid=%b, want 0 0000 0", core_abort, core_load, golden_valid);
    end
    for (int i = 0; i < N; i++) begin
      slice(32'h100, 32'h1FF, i, s, e, u2);
      tick();
      n_checks++;
      if (core_load !== 4'(1 << i) || core_nonce_start !== s || core_nonce_end !== e || golden_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_reload%0d: load=%b start=%h end=%h valid=%b, want %b %h %h 0",
                 i, core_load, core_nonce_start, core_nonce_end, golden_valid, 4'(1 << i), s, e);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (golden_valid !== 1'b0 || core_load !== '0) begin
        n_fail++;
        $display("FAIL abort_no_output%0d: valid=%b nonce=%h load=%b, want 0", c, golden_valid, golden_nonce, core_load);
      end
    end
    nonce_min = 32'h1F; nonce_max = 32'h10; new_work = 1'b1;
    tick();
    new_work = 1'b0;
    n_checks++;
    if (core_abort !== 1'b1 || job_error !== 1'b0 || need_work !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_bad_job: abort=%b job_error=%b need_work=%b, want 1 0 0", core_abort, job_error, need_work);
    end
    tick();
    n_checks++;
    if (core_abort !== 1'b0 || job_error !== 1'b1 || need_work !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_bad_job_err: abort=%b job_error=%b need_work=%b, want 0 1 1", core_abort, job_error, need_work);
    end
    golden_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    int used;
    nonce_min = 32'h0; nonce_max = 32'hFFFF_FFFF; new_work = 1'b1;
    midstate = {8{$urandom}};
    tick();
    new_work = 1'b0;
    tick(); tick();
    n_checks++;
    if (core_load !== 4'b0010) begin
      n_fail++;
      $display("FAIL midload_setup: load=%b, want 0010", core_load);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (need_work !== 1'b1 || core_load !== '0 || core_nonce_start !== '0 || core_nonce_end !== '0 ||
        core_midstate !== '0 || core_data !== '0 || golden_valid !== 1'b0 || overflow_cnt !== '0 ||
        job_error !== 1'b0 || core_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: need_work=%b load=%b start=%h gv=%b ovf=%h, want 1 0 0 0 0",
               need_work, core_load, core_nonce_start, golden_valid, overflow_cnt);
    end
    #1 rst_n = 1'b1;
    tick();
    run_job(32'd5, 32'd6, "post_reset", used);
    finish_job(used, "post_reset");
  endtask

  initial begin
    test_reset();
    test_full_range();
    test_small_invalid();
    test_random_slices();
    test_round_robin();
    test_overflow();
    test_random_arbiter();
    test_abort();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
